// File: rtl/rvv_xrf_wb_arbiter_if.sv
// Retire-slot write-back requests in, one serialised scalar write-back port out.
interface rvv_xrf_wb_arbiter_if #(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [N_SLOTS-1:0]        req_valid_i;
  logic [N_SLOTS*ADDR_W-1:0] req_addr_i;
  logic [N_SLOTS*DATA_W-1:0] req_data_i;
  logic [N_SLOTS-1:0]        req_ready_o;
  logic                      wb_valid_o;
  logic [ADDR_W-1:0]         wb_addr_o;
  logic [DATA_W-1:0]         wb_data_o;
  logic                      wb_ready_i;
  logic [CntW-1:0]           count_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, wb_ready_i,
    output req_ready_o, wb_valid_o, wb_addr_o, wb_data_o, count_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, wb_ready_i,
    input  req_ready_o, wb_valid_o, wb_addr_o, wb_data_o, count_o
  );
endinterface

// File: rtl/rvv_xrf_wb_arbiter.sv
// Multi-push, single-pop FIFO that serialises per-slot scalar write-backs in slot order
// onto the single scalar write-back port.
module rvv_xrf_wb_arbiter #(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input logic                clk,
  input logic                rstn,
  rvv_xrf_wb_arbiter_if.slave bus
);
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned SlotW = $clog2(N_SLOTS + 1);

  typedef logic [PtrW-1:0] ptr_t;

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] free;

  logic [ADDR_W-1:0]  slot_addr [N_SLOTS];
  logic [DATA_W-1:0]  slot_data [N_SLOTS];
  ptr_t               slot_idx  [N_SLOTS];
  logic [N_SLOTS-1:0] ready;
  logic [N_SLOTS-1:0] enq;
  logic [SlotW-1:0]   push_n;
  logic               wb_valid;
  logic               pop;

  // Ready depends only on registered occupancy, so wb_ready_i never reaches req_ready_o.
  always_comb begin
    free   = CntW'(DEPTH) - count_q;
    push_n = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      slot_addr[i] = bus.req_addr_i[i*ADDR_W +: ADDR_W];
      slot_data[i] = bus.req_data_i[i*DATA_W +: DATA_W];
      ready[i]     = rstn && (CntW'(i) < free);
      // x0 writes complete their handshake but never occupy an entry.
      enq[i]       = bus.req_valid_i[i] && ready[i] && (slot_addr[i] != '0);
      slot_idx[i]  = wr_ptr_q + ptr_t'(push_n);
      if (enq[i]) begin
        push_n = push_n + SlotW'(1);
      end
    end
  end

  assign wb_valid = (count_q != '0);
  assign pop      = wb_valid && bus.wb_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + ptr_t'(push_n);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    count_d  = count_q + CntW'(push_n) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Accepted slots land at distinct, consecutive indices; ready guarantees they are free.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (enq[i]) begin
        mem_addr_q[slot_idx[i]] <= slot_addr[i];
        mem_data_q[slot_idx[i]] <= slot_data[i];
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.wb_valid_o  = wb_valid;
  assign bus.wb_addr_o   = wb_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign bus.wb_data_o   = wb_valid ? mem_data_q[rd_ptr_q] : '0;
  assign bus.count_o     = count_q;

  a_count_bound : assert property (@(posedge clk) disable iff (!rstn)
    count_q <= CntW'(DEPTH));
  a_push_fits : assert property (@(posedge clk) disable iff (!rstn)
    CntW'(push_n) <= free);
endmodule

// File: tb/tb_rvv_xrf_wb_arbiter.sv
// Directed bench for rvv_xrf_wb_arbiter: driver models occupancy and queues expected
// write-backs; an independent monitor pops and compares every presented write-back.
module tb_rvv_xrf_wb_arbiter;
  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rvv_xrf_wb_arbiter_if #(.N_SLOTS(N), .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  rvv_xrf_wb_arbiter #(.N_SLOTS(N), .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mcount   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented write-back must match the oldest expected entry.
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.wb_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 64'(bus.wb_valid_o), 64'd0);
      end else begin
        check("wb_addr", 64'(bus.wb_addr_o), 64'(exp_q[0].a));
        check("wb_data", 64'(bus.wb_data_o), 64'(exp_q[0].d));
        if (bus.wb_ready_i === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [N*AW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [N*DW-1:0] pd(input int d0, input int d1, input int d2, input int d3);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  // One clock: drive, check status against the occupancy model at negedge, queue accepts.
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic [N*DW-1:0] d, input logic rdy, input logic rn);
    logic [N-1:0] exp_rdy;
    int           free;
    int           push_n;
    ent_t         e;
    bus.req_valid_i = v;
    bus.req_addr_i  = a;
    bus.req_data_i  = d;
    bus.wb_ready_i  = rdy;
    rstn            = rn;
    @(negedge clk);
    free = DEPTH - mcount;
    for (int i = 0; i < N; i++) exp_rdy[i] = rn && (i < free);
    check("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
    check("count", 64'(bus.count_o), 64'(mcount));
    check("wb_valid", 64'(bus.wb_valid_o), 64'(mcount != 0));
    if (mcount == 0) check("wb_idle_fields", 64'({bus.wb_addr_o, bus.wb_data_o}), 64'd0);
    push_n = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i] && exp_rdy[i] && a[i*AW +: AW] != '0) begin
        e.a = a[i*AW +: AW];
        e.d = d[i*DW +: DW];
        exp_q.push_back(e);
        push_n++;
      end
    end
    if (!rn) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      mcount = mcount + push_n - ((mcount != 0 && rdy) ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step('0, '0, '0, rdy, 1'b1);
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.wb_ready_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step('0, '0, '0, 1'b0, 1'b0);

    // Single write-back through an empty FIFO.
    step(4'b0001, pa(5, 0, 0, 0), pd(32'hA5, 0, 0, 0), 1'b1, 1'b1);
    idle(2, 1'b1);

    // Four slots in one cycle, same register twice: slot 3 must come out last.
    step(4'b1111, pa(1, 2, 3, 1), pd(32'h11, 32'h22, 32'h33, 32'h44), 1'b1, 1'b1);
    idle(5, 1'b1);

    // x0 in slot 1 is consumed without an entry.
    step(4'b0111, pa(7, 0, 9, 0), pd(32'h70, 32'hDEAD, 32'h90, 0), 1'b0, 1'b1);
    idle(1, 1'b0);
    idle(3, 1'b1);

    // Fill to full, back-pressure, then one pop frees exactly one slot.
    step(4'b1111, pa(1, 2, 3, 4), pd(32'h101, 32'h102, 32'h103, 32'h104), 1'b0, 1'b1);
    step(4'b1111, pa(5, 6, 7, 8), pd(32'h105, 32'h106, 32'h107, 32'h108), 1'b0, 1'b1);
    step(4'b1111, pa(9, 10, 11, 12), pd(32'h109, 32'h10A, 32'h10B, 32'h10C), 1'b0, 1'b1);
    step('0, '0, '0, 1'b1, 1'b1);
    step(4'b1111, pa(13, 14, 15, 16), pd(32'h10D, 32'h10E, 32'h10F, 32'h110), 1'b1, 1'b1);
    idle(10, 1'b1);

    // Sustained 3-wide pushes with stalling consumer, wrapping the pointers many times.
    for (int k = 0; k < 60; k++) begin
      step(4'b0111,
           pa(((3*k) % 31) + 1, ((3*k + 1) % 31) + 1, ((3*k + 2) % 31) + 1, 0),
           pd((k << 8) | 0, (k << 8) | 1, (k << 8) | 2, 0),
           (k % 3) != 0, 1'b1);
    end
    idle(40, 1'b1);

    // Reset with five entries queued discards them all.
    step(4'b1111, pa(2, 3, 4, 5), pd(32'h201, 32'h202, 32'h203, 32'h204), 1'b0, 1'b1);
    step(4'b0001, pa(6, 0, 0, 0), pd(32'h205, 0, 0, 0), 1'b0, 1'b1);
    step('0, '0, '0, 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);
    step(4'b0001, pa(10, 0, 0, 0), pd(32'hBEEF, 0, 0, 0), 1'b1, 1'b1);
    idle(2, 1'b1);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rvv_xrf_wb_arbiter.md
# rvv_xrf_wb_arbiter

Collects scalar-register write-backs from the vector backend's `NUM_RT_UOP` retire slots and serialises them onto the single asynchronous scalar write-back port (`async_rd_*`) of the core. Retire slots from one cycle are accepted in slot order (slot 0 oldest) into a multi-push, single-pop FIFO, so program order of scalar writes is preserved. It drains one entry per cycle under a valid/ready handshake. It replaces the current slot-0-only tie-off.

## Interface

Parameters:
- `N_SLOTS`, default 4: number of retire slots; equals `NUM_RT_UOP`.
- `DEPTH`, default 8: FIFO entries; power of two, `DEPTH >= N_SLOTS`.
- `ADDR_W`, default 5: scalar register index width.
- `DATA_W`, default 32: scalar data width.

Ports:
- `clk`, in, 1: single clock. All state updates on its rising edge.
- `rstn`, in, 1: reset, synchronous and active-low.
- `req_valid_i`, in, `N_SLOTS`: per-slot write-back request.
- `req_addr_i`, in, `N_SLOTS*ADDR_W`: per-slot destination register index.
- `req_data_i`, in, `N_SLOTS*DATA_W`: per-slot write data.
- `req_ready_o`, out, `N_SLOTS`: per-slot accept.
- `wb_valid_o`, out, 1: write-back available.
- `wb_addr_o`, out, `ADDR_W`: write-back register index.
- `wb_data_o`, out, `DATA_W`: write-back data.
- `wb_ready_i`, in, 1: consumer accept.
- `count_o`, out, `$clog2(DEPTH+1)`: current FIFO occupancy.

## Operation

- State:
  - storage array `[DEPTH]` of {addr, data};
  - `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`;
  - `count`.
- Capacity: `free = DEPTH - count`, computed from registered `count` only. No combinational path from `wb_ready_i` to `req_ready_o`.
- Ready is a thermometer: `req_ready_o[i] = rstn && (i < free)`. It does not depend on `req_valid_i`.
- Slot `i` is accepted iff `req_valid_i[i] && req_ready_o[i]`.
- Accepted slots are written at `wr_ptr`, `wr_ptr+1`, … in ascending slot index, compacting over non-accepted slots.
- x0 writes: an accepted slot with `req_addr_i == 0` is consumed (handshake completes) but is not enqueued and uses no entry.
- `push_n` = number of accepted non-x0 slots, range 0..`N_SLOTS`.
- `pop = wb_valid_o && wb_ready_i`.
- Per-cycle update:
  - `wr_ptr += push_n`
  - `rd_ptr += pop`
  - `count += push_n - pop`
- Output:
  - `wb_valid_o = (count != 0)`.
  - `wb_addr_o` / `wb_data_o` = entry at `rd_ptr` when valid, else 0.
  - Output fields are held stable while `wb_valid_o && !wb_ready_i`.
- Ordering: entries leave in enqueue order. For two writes to the same register in one cycle, the higher slot index is delivered later.
- Storage is not reset; pointers and `count` are.

## Timing

- Reset (`rstn` low at a rising edge):
  - `count`, `wr_ptr`, `rd_ptr` = 0.
  - `wb_valid_o` = 0; `wb_addr_o` and `wb_data_o` = 0; `count_o` = 0.
  - `req_ready_o` = 0 combinationally while `rstn` is low.
- First cycle after reset: `req_ready_o` = all ones (`DEPTH >= N_SLOTS`).
- Latency: a request accepted in cycle T appears on `wb_*` at T+1 at the earliest (empty FIFO). No same-cycle bypass.
- Throughput: up to `N_SLOTS` pushes per cycle; exactly one pop per cycle while `wb_ready_i` is high.
- Simultaneous push and pop are allowed. Space freed by a pop becomes visible in `req_ready_o` the next cycle.
- Full (`count == DEPTH`): `req_ready_o` = 0. Pop still proceeds.
- Empty: `wb_valid_o` = 0. A push in the same cycle is not visible until next cycle.
- Wrap-around: pointer addition modulo `DEPTH`; a multi-entry push may straddle the wrap point.
- Reset mid-operation: all queued entries are discarded. A `wb_*` transfer in the reset cycle is not counted.
- Invariant (assertion): `count <= DEPTH` always; `push_n <= free` always.

## Test plan

- Reset, then slot 0 = {x5, 0xA5} with `wb_ready_i=1` -> `wb_valid_o` at T+1 with addr 5, data 0xA5; `count_o` returns to 0 at T+2.
- All 4 slots valid in one cycle, addrs 1,2,3,1, `wb_ready_i=1` -> four consecutive outputs in order 1,2,3,1; the last write to x1 carries slot 3's data.
- Slot 1 = x0, slots 0 and 2 valid -> all three handshakes complete; `count_o` = 2; only the two non-x0 entries are output.
- `wb_ready_i=0` with 4-slot pushes on cycles 0 and 1 -> `count_o`=8 and `req_ready_o`=0. Raise `wb_ready_i` -> one pop per cycle; at `count`=7, `req_ready_o`=4'b0001.
- Steady pushes of 3/cycle, `wb_ready_i` toggling, across more than 3 wraps of `wr_ptr` -> the output sequence equals the scoreboard order and the `wb_*` fields are stable while stalled.
- Assert `rstn` low with `count_o`=5 -> next cycle `wb_valid_o`=0, `count_o`=0, `req_ready_o`=0 during reset; after release a new request is delivered normally.
